// File: rtl/alu_seq_if.sv
// alu_seq request/response bundle.
// master drives requests; slave is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();
  logic               start;
  logic [2:0]         sel;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] y;
  logic               carry;
  logic               zero;
  logic               dbz;

  modport master (
    output start, sel, a, b,
    input  busy, done, y, carry, zero, dbz
  );

  modport slave (
    input  start, sel, a, b,
    output busy, done, y, carry, zero, dbz
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle logic/arith ops plus
// iterative shift-add MUL and restoring DIV.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int W  = WIDTH;
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_NOT1 = 3'b110;
  localparam logic [2:0] OP_NOT2 = 3'b111;

  typedef enum logic {IDLE, ITER} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            op_mul;
  logic [W2-1:0]   acc;
  logic [W2-1:0]   opd;
  logic [W-1:0]    shr;

  logic [W:0]      sum;
  logic [W:0]      dif;
  logic [W2-1:0]   res1;
  logic            c1;
  logic            dz1;
  logic            go_iter;

  logic [W2-1:0]   acc_nx;
  logic [W2-1:0]   opd_nx;
  logic [W-1:0]    shr_nx;
  logic [W:0]      shl;
  logic [W:0]      trial;
  logic [W2-1:0]   res_it;

  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b};
    dif     = {1'b0, bus.a} - {1'b0, bus.b};
    res1    = '0;
    c1      = 1'b0;
    dz1     = 1'b0;
    go_iter = 1'b0;
    unique case (1'b1)
      (bus.sel == OP_ADD): begin
        res1 = {{(W-1){1'b0}}, sum};
        c1   = sum[W];
      end
      (bus.sel == OP_SUB): begin
        res1 = {{W{1'b0}}, dif[W-1:0]};
        c1   = dif[W];
      end
      (bus.sel == OP_MUL): go_iter = 1'b1;
      (bus.sel == OP_DIV): begin
        if (bus.b == '0) begin
          res1 = {bus.a, {W{1'b1}}};
          dz1  = 1'b1;
        end else begin
          go_iter = 1'b1;
        end
      end
      (bus.sel == OP_AND):  res1 = {{W{1'b0}}, bus.a & bus.b};
      (bus.sel == OP_OR):   res1 = {{W{1'b0}}, bus.a | bus.b};
      (bus.sel == OP_NOT1): res1 = {{W{1'b0}}, ~bus.a};
      (bus.sel == OP_NOT2): res1 = {{W{1'b0}}, ~bus.b};
      default: ;
    endcase
  end

  // MUL: acc += opd when multiplier LSB set.
  // DIV: acc low half is remainder, shr shifts
  // dividend out and quotient in, opd is divisor.
  always_comb begin
    shl   = {acc[W-1:0], shr[W-1]};
    trial = shl - {1'b0, opd[W-1:0]};
    if (op_mul) begin
      acc_nx = shr[0] ? acc + opd : acc;
      opd_nx = opd << 1;
      shr_nx = shr >> 1;
      res_it = acc_nx;
    end else begin
      opd_nx = opd;
      if (!trial[W]) begin
        acc_nx = {{W{1'b0}}, trial[W-1:0]};
        shr_nx = {shr[W-2:0], 1'b1};
      end else begin
        acc_nx = {{W{1'b0}}, shl[W-1:0]};
        shr_nx = {shr[W-2:0], 1'b0};
      end
      res_it = {acc_nx[W-1:0], shr_nx};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_mul    <= 1'b0;
      acc       <= '0;
      opd       <= '0;
      shr       <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.y     <= '0;
      bus.carry <= 1'b0;
      bus.zero  <= 1'b0;
      bus.dbz   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (go_iter) begin
              state    <= ITER;
              bus.busy <= 1'b1;
              cnt      <= CW'(W);
              acc      <= '0;
              op_mul   <= (bus.sel == OP_MUL);
              if (bus.sel == OP_MUL) begin
                opd <= {{W{1'b0}}, bus.a};
                shr <= bus.b;
              end else begin
                opd <= {{W{1'b0}}, bus.b};
                shr <= bus.a;
              end
            end else begin
              bus.y     <= res1;
              bus.carry <= c1;
              bus.zero  <= (res1 == '0);
              bus.dbz   <= dz1;
              bus.done  <= 1'b1;
            end
          end
        end
        ITER: begin
          acc <= acc_nx;
          opd <= opd_nx;
          shr <= shr_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= IDLE;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            bus.y     <= res_it;
            bus.carry <= 1'b0;
            bus.zero  <= (res_it == '0);
            bus.dbz   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboarded random + directed bench for alu_seq.
// Second instance covers WIDTH=16 multiply.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_seq_if #(.WIDTH(8))  b8 ();
  alu_seq_if #(.WIDTH(16)) b16 ();

  alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] y;
    logic        c;
    logic        z;
    logic        d;
    int          at;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] s,
                                 input logic [7:0] a,
                                 input logic [7:0] b);
    exp_t e;
    int ai, bi, r;
    ai = a;
    bi = b;
    r  = 0;
    e.c = 1'b0;
    e.d = 1'b0;
    case (s)
      3'd0: begin r = ai + bi; e.c = (r > 255); end
      3'd1: begin r = (ai - bi) & 255; e.c = (ai < bi); end
      3'd2: r = ai * bi;
      3'd3: begin
        if (bi == 0) begin
          r = ai * 256 + 255;
          e.d = 1'b1;
        end else begin
          r = (ai % bi) * 256 + ai / bi;
        end
      end
      3'd4: r = ai & bi;
      3'd5: r = ai | bi;
      3'd6: r = 255 - ai;
      default: r = 255 - bi;
    endcase
    e.y  = 16'(r);
    e.z  = (r == 0);
    e.at = 0;
    return e;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b8.done) begin
      chk("busy_low_at_done", 32'(b8.busy), 32'd0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got y=%0h want no done (cyc %0d)",
                 b8.y, cyc);
      end else begin
        e = sb.pop_front();
        chk("y", 32'(b8.y), 32'(e.y));
        chk("carry", 32'(b8.carry), 32'(e.c));
        chk("zero", 32'(b8.zero), 32'(e.z));
        chk("dbz", 32'(b8.dbz), 32'(e.d));
        chk("done_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  int brun = 0;
  int last_run = 0;
  always @(negedge clk) begin
    if (!rst_n) brun = 0;
    else if (b8.busy) brun++;
    else if (brun != 0) begin
      last_run = brun;
      brun = 0;
    end
  end

  task automatic issue(input logic [2:0] s, input logic [7:0] a,
                       input logic [7:0] b);
    exp_t e;
    int k = 0;
    while (b8.busy && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (b8.busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: got busy=1 want 0 (cyc %0d)", cyc);
    end
    e = model(s, a, b);
    e.at = cyc + (((s == 3'd2) || (s == 3'd3 && b != 0)) ? 9 : 1);
    sb.push_back(e);
    b8.sel = s;
    b8.a = a;
    b8.b = b;
    b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    b8.sel = 3'($urandom);
    b8.a = 8'($urandom);
    b8.b = 8'($urandom);
  endtask

  task automatic poke(input logic [2:0] s, input logic [7:0] a,
                      input logic [7:0] b);
    b8.sel = s;
    b8.a = a;
    b8.b = b;
    b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || b8.busy) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [2:0] s;
    logic [7:0] ra, rb;
    int t0, dc;
    logic got;

    b8.start = 1'b0; b8.sel = '0; b8.a = '0; b8.b = '0;
    b16.start = 1'b0; b16.sel = '0; b16.a = '0; b16.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y", 32'(b8.y), 32'd0);
    chk("rst_flags", {28'd0, b8.carry, b8.zero, b8.dbz, b8.busy},
        32'd0);
    chk("rst_done", 32'(b8.done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(3'd0, 8'd200, 8'd100);
    issue(3'd1, 8'd5, 8'd7);
    issue(3'd4, 8'hF0, 8'h3C);
    issue(3'd6, 8'hFF, 8'h00);
    drain();

    issue(3'd2, 8'd255, 8'd255);
    poke(3'd0, 8'd1, 8'd1);
    drain();
    chk("mul_busy_cycles", 32'(last_run), 32'd8);

    issue(3'd3, 8'd200, 8'd7);
    issue(3'd3, 8'h55, 8'h00);
    issue(3'd3, 8'd9, 8'd200);
    drain();

    // Abort a multiply mid-flight
    issue(3'd2, 8'd3, 8'd5);
    @(posedge clk); #1;
    chk("pre_abort_busy", 32'(b8.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("abort_y", 32'(b8.y), 32'd0);
    chk("abort_flags", {28'd0, b8.carry, b8.zero, b8.dbz, b8.busy},
        32'd0);
    chk("abort_done", 32'(b8.done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    issue(3'd0, 8'd1, 8'd1);
    drain();

    issue(3'd0, 8'd17, 8'd34);
    issue(3'd5, 8'h81, 8'h18);
    issue(3'd1, 8'd0, 8'd1);
    drain();

    // WIDTH=16 multiply
    b16.sel = 3'd2;
    b16.a = 16'hFFFF;
    b16.b = 16'hFFFF;
    b16.start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    b16.start = 1'b0;
    got = 1'b0;
    dc = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (b16.done) begin
        got = 1'b1;
        dc = cyc;
      end
    end
    chk("w16_done_seen", 32'(got), 32'd1);
    chk("w16_y", b16.y, 32'hFFFE0001);
    chk("w16_latency", 32'(dc - t0), 32'd17);
    @(posedge clk); #1;

    for (int i = 0; i < 300; i++) begin
      s  = 3'($urandom);
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      issue(s, ra, rb);
      if (b8.busy && $urandom_range(0, 3) == 0)
        poke(3'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk); #1;
      end
    end
    drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's combinational 8-op ALU. It adds a start/busy/done handshake, an iterative shift-add multiplier, a restoring divider, true bitwise logic ops, and status flags. It sits between a sequencer or register file and the writeback path; operands are captured on `start`, and the result is held until the next completion.

## Interface
- `WIDTH`, default 8: operand width in bits; must be ≥ 2. Result width is 2·WIDTH.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request; sampled only when `busy`=0.
- `sel` input, 3 bits: opcode. ADD=000, SUB=001, MUL=010, DIV=011, AND=100, OR=101, NOT1=110, NOT2=111.
- `a` input, WIDTH bits: operand A, unsigned.
- `b` input, WIDTH bits: operand B, unsigned.
- `busy` output, 1 bit: iterative MUL/DIV in progress.
- `done` output, 1 bit: one-cycle completion pulse.
- `y` output, 2·WIDTH bits: registered result.
- `carry` output, 1 bit: ADD carry-out or SUB borrow; 0 for all other ops.
- `zero` output, 1 bit: `y`==0 for the latched result.
- `dbz` output, 1 bit: last DIV had `b`==0.

## Operation
- The FSM has two states, IDLE and ITER. Reset puts it in IDLE, and `busy`, `done`, `y`, `carry`, `zero` and `dbz` all reset to 0.
- IDLE with `start`=1: latch `a`, `b` and `sel`.
  - ADD, SUB, AND, OR, NOT1, NOT2: compute, write `y` and the flags, and pulse `done` at the same edge. Stay in IDLE.
  - DIV with `b`=0: write `y`={a, all-ones quotient}, `dbz`=1, pulse `done`. Stay in IDLE.
  - MUL, or DIV with `b`≠0: go to ITER, set `busy`=1, load the iteration counter with WIDTH, and clear the accumulator.
- ITER runs one iteration per cycle and decrements the counter.
  - MUL: shift-add, LSB of multiplier first.
  - DIV: restoring, MSB of dividend first.
  - On the edge where the counter reaches 0: write `y` and the flags, pulse `done`, clear `busy`, return to IDLE.
- `start` during ITER is ignored and does not queue. Operand or `sel` changes during ITER have no effect.
- Result formats (upper bits zero unless stated):
  - ADD: `y`[WIDTH:0]=a+b; `carry`=bit WIDTH.
  - SUB: `y`[WIDTH-1:0]=(a−b) mod 2^WIDTH; `carry`=1 iff a<b.
  - MUL: `y`=a·b, full 2·WIDTH-bit unsigned product.
  - DIV: `y`[WIDTH-1:0]=quotient, `y`[2·WIDTH-1:WIDTH]=remainder.
  - AND/OR: bitwise a&b, a|b.
  - NOT1/NOT2: bitwise ~a, ~b.
- Flag updates:
  - `zero`: recomputed on every completion.
  - `carry`: cleared on every completion that is not ADD/SUB.
  - `dbz`: cleared on every completion that is not a divide-by-zero DIV.
- `y` and the flags hold their values between completions. `done` is never high for more than one cycle per request.
- Reset asserted mid-ITER aborts the operation immediately. No `done` is produced, and all outputs return to their reset values.

## Timing
- Single-cycle ops, and DIV by 0: `start` is sampled at edge N. `y`, the flags and `done`=1 are visible after edge N, so latency is 1. `done` drops after edge N+1 unless another request is accepted at edge N+1.
- MUL and DIV (b≠0): `start` is sampled at edge N, and `busy`=1 after edge N. Iterations occur at edges N+1 … N+WIDTH. `y`, `done`=1 and `busy`=0 are visible after edge N+WIDTH, so latency is WIDTH+1 edges.
- Back-to-back: a new `start` is accepted in the cycle where `done`=1, because `busy` is already 0. The throughput is one single-cycle op per clock.
- `busy` and `done` are never both 1.

## Test plan
- Reset, then ADD a=200, b=100: `y`=0x012C, `carry`=1, `zero`=0, `done` for 1 cycle, 1 edge after `start`.
- SUB a=5, b=7: `y`=0x00FE, `carry`=1. Then AND a=0xF0, b=0x3C: `y`=0x0030, `carry`=0. Then NOT1 a=0xFF: `y`=0, `zero`=1.
- MUL a=255, b=255 (WIDTH=8): `busy` high for exactly 8 cycles, then `y`=0xFE01 with `done` 9 edges after `start`. Pulsing `start` with ADD mid-operation is ignored, and `y` still equals 0xFE01.
- DIV a=200, b=7: `y`=0x041C (r=4, q=28), `dbz`=0, latency 9 edges. Then DIV a=0x55, b=0: `y`=0x55FF, `dbz`=1, latency 1.
- Assert `rst_n` low during ITER of MUL: outputs go to 0 immediately, and no `done` follows. After release, a new ADD 1+1 gives `y`=2.
- Back-to-back ADD, OR, SUB on consecutive cycles: three consecutive `done` pulses with correct `y` for each. Also rerun with WIDTH=16 MUL 0xFFFF·0xFFFF giving `y`=0xFFFE0001 at latency 17 edges.
